alu_result_serializer: RTL

- Downstream stage of the system ALU: captures each 16-bit result qualified by the ALU's registered OUT_VALID pulse.
- Buffers results in a small synchronous FIFO and serializes each one as two bytes, LSB first, onto a valid/ready byte stream.
- That byte stream feeds the UART TX path of the register-file/command controller.
- Decouples the single-cycle ALU result pulse from a back-pressured transmit path.

---
 rtl/alu_sys_pkg.sv | 22 ++
 rtl/sync_result_fifo.sv | 56 +++++
 rtl/alu_result_serializer.sv | 91 +++++++++
 3 files changed

// File: rtl/alu_sys_pkg.sv
// Shared ALU-system definitions: widths, serializer
// state encoding and byte-select constants.
package alu_sys_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int OUT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } tx_state_t;

    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    // Which half of the head word a given state presents
    function automatic logic byte_sel(input tx_state_t s);
        return (s == SEND_HI) ? BYTE_HI : BYTE_LO;
    endfunction

endpackage

// File: rtl/sync_result_fifo.sv
// Small synchronous FIFO with a combinational head
// output; pointers and count reset synchronously.
module sync_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams each one as two
// bytes, LSB first, on a valid/ready byte interface.
module alu_result_serializer #(
    parameter int DATA_WIDTH = alu_sys_pkg::DATA_WIDTH,
    parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
    parameter int DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  OUT_VALID,
    input  logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_VALID,
    output logic                  BUSY,
    output logic                  OVERFLOW
);

    import alu_sys_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    tx_state_t            state;
    logic [OUT_WIDTH-1:0] head;
    logic [CW-1:0]        count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    assign pop  = (state == SEND_HI) && TX_READY;
    assign push = OUT_VALID && (!full || pop);

    sync_result_fifo #(
        .WIDTH(OUT_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (push),
        .pop  (pop),
        .din  (ALU_OUT),
        .head (head),
        .full (full),
        .empty(empty),
        .count(count)
    );

    // Byte sequencer and sticky overflow flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            OVERFLOW <= 1'b0;
        end else begin
            if (OUT_VALID && full && !pop) begin
                OVERFLOW <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (!empty) state <= SEND_LO;
                end
                SEND_LO: begin
                    if (TX_READY) state <= SEND_HI;
                end
                SEND_HI: begin
                    if (TX_READY) begin
                        state <= (count > CW'(1)) ? SEND_LO : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output byte mux driven only from registered state and FIFO head
    always_comb begin
        TX_DATA = '0;
        if (state != IDLE) begin
            if (byte_sel(state) == BYTE_HI) begin
                TX_DATA = head[OUT_WIDTH-1:DATA_WIDTH];
            end else begin
                TX_DATA = head[DATA_WIDTH-1:0];
            end
        end
    end

    assign TX_VALID = (state != IDLE);
    assign BUSY     = !empty || (state != IDLE);

endmodule
